// File: rtl/sample_feeder.sv
// rtl/sample_feeder.sv - circular sample FIFO serving the FIR filter's req/ack input, with stall counter
module sample_feeder #(
    parameter int DWIDTH = 16,
    parameter int DEPTH  = 16,
    parameter int AWIDTH = 4,
    parameter int SWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DWIDTH-1:0] wr_data,
    output logic              full,
    output logic [AWIDTH:0]   count,
    output logic              overflow,
    input  logic              sink_req,
    output logic              sink_ack,
    output logic [DWIDTH-1:0] sink_data,
    output logic [SWIDTH-1:0] stall_cycles
);
    localparam logic [AWIDTH:0] FULL_COUNT = (AWIDTH+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [AWIDTH:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              ack_q, ack_d;
    logic [DWIDTH-1:0] data_q, data_d;
    logic [SWIDTH-1:0] stall_q, stall_d;
    logic              pop;
    logic              wr_accept;
    logic              fifo_empty;

    assign fifo_empty = (count_q == '0);
    assign full       = (count_q == FULL_COUNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (sink_req) begin
                    state_d = fifo_empty ? ST_WAIT : ST_ACK;
                end
            end
            ST_WAIT: begin
                if (!fifo_empty) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!sink_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The single pop of a handshake happens on the edge that enters ACK.
    always_comb begin
        pop     = (state_d == ST_ACK) && (state_q != ST_ACK);
        ack_d   = (state_d == ST_ACK);
        data_d  = pop ? mem_q[rd_ptr_q] : data_q;
        stall_d = stall_q;
        if ((state_q == ST_WAIT) && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    // A full FIFO still takes a write when the same cycle frees a slot.
    always_comb begin
        wr_accept  = wr_en && (!full || pop);
        overflow_d = overflow_q || (wr_en && !wr_accept);
        wr_ptr_d   = wr_accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        case ({wr_accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_accept) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            ack_q      <= 1'b0;
            data_q     <= '0;
            stall_q    <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            ack_q      <= ack_d;
            data_q     <= data_d;
            stall_q    <= stall_d;
        end
    end

    assign count        = count_q;
    assign overflow     = overflow_q;
    assign sink_ack     = ack_q;
    assign sink_data    = data_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_sample_feeder.sv
// tb/tb_sample_feeder.sv - randomized self-checking bench for sample_feeder against a queue-based model
module tb_sample_feeder;
    localparam int DWIDTH    = 16;
    localparam int DEPTH     = 16;
    localparam int AWIDTH    = 4;
    localparam int SWIDTH    = 16;
    localparam int STALL_MAX = (1 << SWIDTH) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [DWIDTH-1:0] wr_data;
    logic              full;
    logic [AWIDTH:0]   count;
    logic              overflow;
    logic              sink_req;
    logic              sink_ack;
    logic [DWIDTH-1:0] sink_data;
    logic [SWIDTH-1:0] stall_cycles;

    sample_feeder #(
        .DWIDTH(DWIDTH),
        .DEPTH (DEPTH),
        .AWIDTH(AWIDTH),
        .SWIDTH(SWIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .count       (count),
        .overflow    (overflow),
        .sink_req    (sink_req),
        .sink_ack    (sink_ack),
        .sink_data   (sink_data),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: buffered samples, expected handshake outputs, sticky flags.
    logic [DWIDTH-1:0] q[$];
    logic              m_ack;
    logic [DWIDTH-1:0] m_data;
    logic              m_ovf;
    logic              m_wait;
    int                m_stall;

    // Samples seen by the filter, captured from the DUT on each ack rise.
    logic [DWIDTH-1:0] got[$];
    logic              dut_ack_seen;

    // Filter behaviour model.
    logic f_on;
    logic f_stopping;
    int   f_phase;
    int   f_cnt;
    int   f_gap_max;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic filter_drive();
        if (!f_on) return;
        case (f_phase)
            0: begin
                if (f_cnt > 0) begin
                    f_cnt--;
                end else if (!sink_ack && !f_stopping) begin
                    sink_req = 1'b1;
                    f_phase  = 1;
                end
            end
            1: begin
                if (sink_ack) begin
                    f_cnt   = $urandom_range(0, 2);
                    f_phase = 2;
                end
            end
            2: begin
                if (f_cnt > 0) begin
                    f_cnt--;
                end else begin
                    sink_req = 1'b0;
                    f_cnt    = $urandom_range(0, f_gap_max);
                    f_phase  = 0;
                end
            end
            default: f_phase = 0;
        endcase
    endtask

    task automatic tick();
        logic              p_rst, p_wr, p_req, p_ack, p_wait, pop;
        logic [DWIDTH-1:0] p_d;
        int                p_size;
        p_rst  = rst;
        p_wr   = wr_en;
        p_req  = sink_req;
        p_ack  = m_ack;
        p_wait = m_wait;
        p_d    = wr_data;
        p_size = q.size();
        @(posedge clk);
        #1;
        if (p_rst) begin
            q.delete();
            m_ack   = 1'b0;
            m_data  = '0;
            m_ovf   = 1'b0;
            m_wait  = 1'b0;
            m_stall = 0;
        end else begin
            pop = !p_ack && p_req && (p_size > 0);
            if (p_ack && !p_req) m_ack = 1'b0;
            if (pop) begin
                m_data = q.pop_front();
                m_ack  = 1'b1;
            end
            if (p_wait && (m_stall < STALL_MAX)) m_stall++;
            m_wait = !p_ack && p_req && (p_size == 0);
            if (p_wr) begin
                if ((p_size < DEPTH) || pop) q.push_back(p_d);
                else m_ovf = 1'b1;
            end
        end
        if (sink_ack && !dut_ack_seen) got.push_back(sink_data);
        dut_ack_seen = sink_ack;
        check("ack", sink_ack, m_ack);
        check("data", sink_data, m_data);
        check("count", count, q.size());
        check("full", full, (q.size() == DEPTH));
        check("overflow", overflow, m_ovf);
        check("stall", stall_cycles, m_stall);
        filter_drive();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        wr_en    = 1'b0;
        sink_req = 1'b0;
        f_on     = 1'b0;
        f_phase  = 0;
        f_cnt    = 0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic filter_start(input int gap_max);
        got.delete();
        f_gap_max = gap_max;
        f_phase   = 0;
        f_cnt     = 0;
        f_on      = 1'b1;
    endtask

    // Lets the filter finish its current handshake; feeds a word if it is starving.
    task automatic filter_stop();
        f_stopping = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if ((f_phase == 0) && !sink_req && !sink_ack) break;
            wr_en   = (f_phase == 1) && (q.size() == 0) && !sink_ack;
            wr_data = DWIDTH'($urandom);
            tick();
        end
        wr_en      = 1'b0;
        f_on       = 1'b0;
        f_stopping = 1'b0;
        check("filter_quiet", {sink_req, sink_ack}, 2'b00);
    endtask

    initial begin
        logic [DWIDTH-1:0] sv;
        int                nv;
        int                thr;

        rst = 1'b1; wr_en = 1'b0; wr_data = '0; sink_req = 1'b0;
        f_on = 1'b0; f_stopping = 1'b0; f_phase = 0; f_cnt = 0; f_gap_max = 0;
        m_ack = 1'b0; m_data = '0; m_ovf = 1'b0; m_wait = 1'b0; m_stall = 0;
        dut_ack_seen = 1'b0;

        // Reset values, then a request on an empty FIFO goes to WAIT
        tick();
        tick();
        check("rst_ack", sink_ack, 0);
        check("rst_data", sink_data, 0);
        check("rst_count", count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_stall", stall_cycles, 0);
        rst = 1'b0;
        sink_req = 1'b1;
        tick(); tick(); tick();
        check("rst_wait_stall", stall_cycles, 2);
        check("rst_wait_noack", sink_ack, 0);
        do_reset();

        // Single transfer
        wr_en = 1'b1; wr_data = 16'h1234;
        tick();
        wr_en = 1'b0;
        check("t2_count1", count, 1);
        sink_req = 1'b1;
        tick();
        check("t2_ack", sink_ack, 1);
        check("t2_data", sink_data, 16'h1234);
        check("t2_count0", count, 0);
        tick();
        sink_req = 1'b0;
        tick();
        check("t2_ack_drop", sink_ack, 0);

        // Fill and overflow, then drain in order
        for (int i = 1; i <= 17; i++) begin
            wr_en = 1'b1; wr_data = DWIDTH'(i);
            tick();
        end
        wr_en = 1'b0;
        check("t3_full", full, 1);
        check("t3_count", count, 16);
        check("t3_overflow", overflow, 1);
        filter_start(2);
        for (int c = 0; c < 400 && got.size() < 16; c++) tick();
        filter_stop();
        check("t3_n", got.size(), 16);
        for (int i = 0; i < got.size(); i++) check("t3_order", got[i], i + 1);
        check("t3_empty", count, 0);
        check("t3_ovf_sticky", overflow, 1);

        // Wrap with continuous reading
        do_reset();
        filter_start(0);
        nv = 0;
        for (int c = 0; c < 2000 && got.size() < 40; c++) begin
            wr_en   = (nv < 40) && !full && ($urandom_range(0, 1) == 1);
            wr_data = DWIDTH'(nv);
            if (wr_en) nv++;
            tick();
        end
        wr_en = 1'b0;
        filter_stop();
        check("t4_n", got.size(), 40);
        for (int i = 0; i < got.size() && i < 40; i++) check("t4_order", got[i], i);
        check("t4_no_overflow", overflow, 0);

        // Starvation: 10 WAIT cycles, write -> ack two cycles later
        do_reset();
        sink_req = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        sv = DWIDTH'($urandom);
        wr_en = 1'b1; wr_data = sv;
        tick();
        wr_en = 1'b0;
        check("t5_ack_early", sink_ack, 0);
        tick();
        check("t5_ack", sink_ack, 1);
        check("t5_data", sink_data, sv);
        check("t5_stall", stall_cycles, 10);
        tick();
        sink_req = 1'b0;
        tick();
        check("t5_ack_drop", sink_ack, 0);

        // Reset in the middle of ACK, then filter in the loop again
        do_reset();
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1; wr_data = DWIDTH'($urandom);
            tick();
        end
        wr_en = 1'b0;
        sink_req = 1'b1;
        tick();
        check("t6_ack_before", sink_ack, 1);
        rst = 1'b1; sink_req = 1'b0;
        tick();
        rst = 1'b0;
        check("t6_ack", sink_ack, 0);
        check("t6_count", count, 0);
        check("t6_overflow", overflow, 0);
        filter_start(1);
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = DWIDTH'(16'hA000 + i);
            tick();
        end
        wr_en = 1'b0;
        for (int c = 0; c < 200 && got.size() < 5; c++) tick();
        filter_stop();
        check("t6_n", got.size(), 5);
        for (int i = 0; i < got.size() && i < 5; i++) check("t6_data", got[i], 16'hA000 + i);

        // Random traffic: light load with starvation, then heavy load with overflow
        do_reset();
        filter_start(3);
        for (int c = 0; c < 1500; c++) begin
            thr     = (c < 750) ? 20 : 65;
            wr_en   = ($urandom_range(0, 99) < thr);
            wr_data = DWIDTH'($urandom);
            tick();
        end
        wr_en = 1'b0;
        filter_stop();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
